wb_regfile: RTL and testbench

Writeback stage and 32 x 64-bit register file, the write-side counterpart of the instruction decode stage. It captures results from the execute path, applies the PPPWW lane/width mask, and commits the merged value to the destination register. It also serves the two decode-stage read ports, with optional forwarding. A per-register in-flight write scoreboard lets decode detect read-after-write hazards.

---
 rtl/wb_regfile.sv | 170 +++++++++++++++++
 tb/tb_wb_regfile.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage plus 32 x 64-bit register file.
// Captures execute results into a one-entry stage, commits them to the
// array with a PPPWW lane/width mask one edge later, serves two
// combinational read ports and keeps a per-register count of in-flight
// writes for decode hazard detection.
// Optional feature macro: WB_FORWARD_EN (forward the merged staged value
// to the read ports and discount it from the hazard check).
`timescale 1ns/1ps

// Per-register pending-write counter: saturating increment on issue,
// floored decrement on commit, no change when both hit together.
module wb_regfile_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt
);
  logic [CW-1:0] r_cnt;

  // Counter update; protocol-error issues at saturation leave it saturated.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_inc && !i_dec && (r_cnt != '1))
      r_cnt <= r_cnt + CW'(1);
    else if (i_dec && !i_inc && (r_cnt != '0))
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_cnt = r_cnt;
endmodule

module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 64,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic          wb_en,
  input  logic [4:0]    wb_rD,
  input  logic [0:4]    wb_PPPWW,
  input  logic [0:DW-1] wb_data,
  input  logic          iss_valid,
  input  logic          iss_wb_en,
  input  logic [4:0]    iss_rD,
  output logic          iss_full,
  input  logic [4:0]    rd_a_addr,
  input  logic [4:0]    rd_b_addr,
  output logic [0:DW-1] rd_a_data,
  output logic [0:DW-1] rd_b_data,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [15:0]   commit_count
);

  // Lane mask: bit 0 is the MSB; lane size is 8 << WW, lane 0 is the top.
  function automatic logic [0:DW-1] f_mask(input logic [0:4] pppww);
    logic [0:DW-1] m;
    logic [2:0]    ppp;
    logic [1:0]    ww;
    int            sh;
    int            nl;
    int            lane;
    ppp = pppww[0:2];
    ww  = pppww[3:4];
    sh  = 3 + int'(ww);
    nl  = DW >> sh;
    m   = '0;
    for (int i = 0; i < DW; i++) begin
      lane = i >> sh;
      case (ppp)
        3'd0:    m[i] = 1'b1;
        3'd1:    m[i] = (nl == 1) || (lane < nl / 2);  // single lane: lane 0
        3'd2:    m[i] = (lane >= nl / 2);
        3'd3:    m[i] = (lane % 2 == 0);
        3'd4:    m[i] = (lane % 2 == 1);
        default: m[i] = 1'b0;
      endcase
    end
    return m;
  endfunction

  logic             r_s_valid;
  logic [4:0]       r_s_rD;
  logic [0:4]       r_s_PPPWW;
  logic [0:DW-1]    r_s_data;
  logic [0:DW-1]    r_regs [NREG];
  logic [15:0]      r_commit_count;

  logic [0:DW-1]        w_mask;
  logic [0:DW-1]        w_merged;
  logic [NREG-1:0]      w_inc;
  logic [NREG-1:0]      w_dec;
  logic [NREG-1:0][CW-1:0] w_cnt;
  logic                 w_fwd_a;
  logic                 w_fwd_b;

  // Staged value merged against current array contents; used for the
  // commit and, when forwarding, for the read ports.
  assign w_mask   = f_mask(r_s_PPPWW);
  assign w_merged = (r_regs[r_s_rD] & ~w_mask) | (r_s_data & w_mask);

  // Capture stage: load on a real writeback, otherwise drop s_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_valid <= 1'b0;
      r_s_rD    <= '0;
      r_s_PPPWW <= '0;
      r_s_data  <= '0;
    end else if (wb_valid && wb_en) begin
      r_s_valid <= 1'b1;
      r_s_rD    <= wb_rD;
      r_s_PPPWW <= wb_PPPWW;
      r_s_data  <= wb_data;
    end else begin
      r_s_valid <= 1'b0;
    end
  end

  // Commit: r0 writes are dropped but still counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_commit_count <= '0;
    end else if (r_s_valid) begin
      if (r_s_rD != '0) r_regs[r_s_rD] <= w_merged;
      r_commit_count <= r_commit_count + 16'd1;
    end
  end

  // Scoreboard counters; r0 never tracks anything.
  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    assign w_inc[g] = (g != 0) && iss_valid && iss_wb_en && (iss_rD == 5'(g));
    assign w_dec[g] = (g != 0) && r_s_valid && (r_s_rD == 5'(g));
    wb_regfile_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_inc[g]),
      .i_dec (w_dec[g]),
      .o_cnt (w_cnt[g])
    );
  end

`ifdef WB_FORWARD_EN
  assign w_fwd_a = r_s_valid && (r_s_rD == rd_a_addr) && (rd_a_addr != '0);
  assign w_fwd_b = r_s_valid && (r_s_rD == rd_b_addr) && (rd_b_addr != '0);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  // Read ports and hazard flags; a forwarded staged write is not a hazard.
  always_comb begin
    rd_a_data = '0;
    rd_b_data = '0;
    if (rd_a_addr != '0) rd_a_data = w_fwd_a ? w_merged : r_regs[rd_a_addr];
    if (rd_b_addr != '0) rd_b_data = w_fwd_b ? w_merged : r_regs[rd_b_addr];
    hazard_a = (rd_a_addr != '0) && (w_cnt[rd_a_addr] > CW'(w_fwd_a));
    hazard_b = (rd_b_addr != '0) && (w_cnt[rd_b_addr] > CW'(w_fwd_b));
  end

  assign iss_full     = &w_cnt[iss_rD];
  assign commit_count = r_commit_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, full and masked writes, r0,
// scoreboard saturation and back-to-back merging. Build with or without
// WB_FORWARD_EN; the latency-dependent expectations follow the macro.
`timescale 1ns/1ps

module tb_wb_regfile;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_rD;
  logic [4:0]  wb_PPPWW;
  logic [63:0] wb_data;
  logic        iss_valid, iss_wb_en;
  logic [4:0]  iss_rD;
  logic        iss_full;
  logic [4:0]  rd_a_addr, rd_b_addr;
  logic [63:0] rd_a_data, rd_b_data;
  logic        hazard_a, hazard_b;
  logic [15:0] commit_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cc = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_en(wb_en), .wb_rD(wb_rD),
    .wb_PPPWW(wb_PPPWW), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_wb_en(iss_wb_en), .iss_rD(iss_rD),
    .iss_full(iss_full),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .commit_count(commit_count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_set(input logic [4:0] rd, input logic [4:0] p, input logic [63:0] d);
    wb_valid = 1'b1; wb_en = 1'b1; wb_rD = rd; wb_PPPWW = p; wb_data = d;
  endtask

  task automatic wb_clr();
    wb_valid = 1'b0; wb_en = 1'b0;
  endtask

  task automatic iss_set(input logic [4:0] rd);
    iss_valid = 1'b1; iss_wb_en = 1'b1; iss_rD = rd;
  endtask

  task automatic iss_clr();
    iss_valid = 1'b0; iss_wb_en = 1'b0;
  endtask

  // Present a writeback for one cycle and wait until it has committed.
  task automatic wb_one(input logic [4:0] rd, input logic [4:0] p, input logic [63:0] d);
    wb_set(rd, p, d); tick(); wb_clr(); tick();
    exp_cc++;
  endtask

  initial begin
    rst = 1'b1; wb_clr(); wb_rD = '0; wb_PPPWW = '0; wb_data = '0;
    iss_clr(); iss_rD = '0; rd_a_addr = '0; rd_b_addr = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset during a staged write to r5 with one pending issue.
    rd_a_addr = 5'd5; rd_b_addr = 5'd31;
    iss_set(5'd5); tick(); iss_clr();
    chk("pre_rst_hazard", 64'(hazard_a), 64'd1);
    wb_set(5'd5, 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF); tick(); wb_clr();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_rd_a", rd_a_data, 64'd0);
    chk("rst_rd_b", rd_b_data, 64'd0);
    chk("rst_haz_a", 64'(hazard_a), 64'd0);
    chk("rst_haz_b", 64'(hazard_b), 64'd0);
    chk("rst_cc", 64'(commit_count), 64'd0);
    iss_rD = 5'd5;
    chk("rst_full", 64'(iss_full), 64'd0);
    tick();
    chk("rst_r5_stays", rd_a_data, 64'd0);
    chk("rst_cc_stays", 64'(commit_count), 64'd0);

    // Full write to r3 with hazard timing.
    rd_a_addr = 5'd3;
    iss_set(5'd3); tick(); iss_clr();
    chk("r3_haz_issued", 64'(hazard_a), 64'd1);
    wb_set(5'd3, 5'b00011, 64'h0123_4567_89AB_CDEF);
    chk("r3_haz_cycN", 64'(hazard_a), 64'd1);
    tick(); wb_clr();
    chk("r3_data_N1", rd_a_data, FWD ? 64'h0123_4567_89AB_CDEF : 64'd0);
    chk("r3_haz_N1", 64'(hazard_a), FWD ? 64'd0 : 64'd1);
    chk("r3_cc_N1", 64'(commit_count), 64'd0);
    tick(); exp_cc++;
    chk("r3_data_N2", rd_a_data, 64'h0123_4567_89AB_CDEF);
    chk("r3_haz_N2", 64'(hazard_a), 64'd0);
    chk("r3_cc_N2", 64'(commit_count), 64'(exp_cc));

    // Lane masking on r4.
    rd_b_addr = 5'd4;
    wb_one(5'd4, 5'b00011, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("r4_ones", rd_b_data, 64'hFFFF_FFFF_FFFF_FFFF);
    wb_one(5'd4, 5'b01100, 64'd0);                 // even bytes
    chk("r4_even_bytes", rd_b_data, 64'h00FF_00FF_00FF_00FF);
    wb_one(5'd4, 5'b01001, 64'd0);                 // lower half-words
    chk("r4_low_halfwords", rd_b_data, 64'h00FF_00FF_0000_0000);
    wb_one(5'd4, 5'b00110, 64'hFFFF_FFFF_FFFF_FFFF); // upper word
    chk("r4_upper_word", rd_b_data, 64'hFFFF_FFFF_0000_0000);
    wb_one(5'd4, 5'b10111, 64'd0);                 // PPP=101: no change
    chk("r4_ppp101", rd_b_data, 64'hFFFF_FFFF_0000_0000);
    wb_one(5'd4, 5'b10011, 64'd0);                 // odd lanes of 1: none
    chk("r4_odd_ww11", rd_b_data, 64'hFFFF_FFFF_0000_0000);
    wb_one(5'd4, 5'b00111, 64'h1122_3344_5566_7788); // upper of 1 lane: all
    chk("r4_upper_ww11", rd_b_data, 64'h1122_3344_5566_7788);
    chk("r4_cc", 64'(commit_count), 64'(exp_cc));
    // NOP writeback (wb_en=0) is ignored.
    wb_valid = 1'b1; wb_en = 1'b0; wb_rD = 5'd4; wb_PPPWW = 5'b00011; wb_data = '0;
    tick(); wb_clr(); tick();
    chk("nop_data", rd_b_data, 64'h1122_3344_5566_7788);
    chk("nop_cc", 64'(commit_count), 64'(exp_cc));

    // Register 0: issues never count, writes are dropped but counted.
    rd_a_addr = 5'd0;
    iss_set(5'd0); tick(); tick(); tick(); iss_clr();
    chk("r0_full", 64'(iss_full), 64'd0);
    wb_one(5'd0, 5'b00011, 64'h0000_0000_0000_DEAD);
    chk("r0_data", rd_a_data, 64'd0);
    chk("r0_haz", 64'(hazard_a), 64'd0);
    chk("r0_cc", 64'(commit_count), 64'(exp_cc));

    // Scoreboard saturation on r7.
    rd_b_addr = 5'd7;
    iss_set(5'd7); tick(); tick(); tick(); iss_valid = 1'b0;
    chk("r7_full3", 64'(iss_full), 64'd1);
    chk("r7_haz3", 64'(hazard_b), 64'd1);
    iss_valid = 1'b1; tick(); iss_valid = 1'b0;      // issue while full
    chk("r7_full_sat", 64'(iss_full), 64'd1);
    wb_set(5'd7, 5'b00011, 64'h7777_7777_7777_7777); tick(); wb_clr();
    chk("r7_haz_staged", 64'(hazard_b), 64'd1);
    tick(); exp_cc++;
    chk("r7_full_after_commit", 64'(iss_full), 64'd0);
    chk("r7_haz_after_commit", 64'(hazard_b), 64'd1);
    chk("r7_data", rd_b_data, 64'h7777_7777_7777_7777);
    // Issue and commit on the same edge: count stays at 2.
    wb_set(5'd7, 5'b00011, 64'h0707_0707_0707_0707); tick(); wb_clr();
    iss_valid = 1'b1; tick(); iss_valid = 1'b0; exp_cc++;
    chk("r7_same_edge_full", 64'(iss_full), 64'd0);
    chk("r7_same_edge_haz", 64'(hazard_b), 64'd1);
    iss_valid = 1'b1; tick(); iss_clr();
    chk("r7_count_was_2", 64'(iss_full), 64'd1);
    chk("r7_cc", 64'(commit_count), 64'(exp_cc));

    // Back-to-back merge on r9.
    rd_a_addr = 5'd9;
    wb_set(5'd9, 5'b00110, 64'hAAAA_AAAA_AAAA_AAAA); tick();
    wb_set(5'd9, 5'b01010, 64'h5555_5555_5555_5555); tick(); wb_clr();
    chk("r9_mid", rd_a_data, FWD ? 64'hAAAA_AAAA_5555_5555 : 64'hAAAA_AAAA_0000_0000);
    tick(); exp_cc += 2;
    chk("r9_merge", rd_a_data, 64'hAAAA_AAAA_5555_5555);
    chk("r9_cc", 64'(commit_count), 64'(exp_cc));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
